data_cache: RTL

//  Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and a

---
 rtl/cache_pkg.sv | 42 ++++
 rtl/data_cache_if.sv | 43 ++++
 rtl/cache_line_store.sv | 76 +++++++
 rtl/data_cache.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : cache_pkg
//  Purpose   : Shared types, geometry constants and width helpers for data_cache
//  Revision  : 1.0  initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = LINE_BYTES / 4;
    localparam int LINE_W         = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } cache_state_e;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } mem_req_t;

    function automatic int offset_width();
        return $clog2(LINE_BYTES);
    endfunction

    function automatic int index_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_width(input int num_sets);
        return ADDR_W - index_width(num_sets) - offset_width();
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
//  Interface : data_cache_if
//  Purpose   : CPU request/response and backing-memory line bus of data_cache
//  Revision  : 1.0  initial release
// ============================================================================
interface data_cache_if;
    import cache_pkg::*;

    logic                is_input_valid;
    logic [ADDR_W-1:0]   addr;
    logic                mem_read;
    logic                mem_write;
    logic [WORD_W-1:0]   din;
    logic                is_ready;
    logic                is_output_valid;
    logic [WORD_W-1:0]   dout;
    logic                is_hit;

    logic                mem_req_valid;
    logic                mem_req_we;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [LINE_W-1:0]   mem_req_wdata;
    logic                mem_resp_valid;
    logic [LINE_W-1:0]   mem_resp_data;

    // master: the CPU pipeline plus backing memory surrounding the cache
    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        output mem_resp_valid, mem_resp_data,
        input  is_ready, is_output_valid, dout, is_hit,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        input  mem_resp_valid, mem_resp_data,
        output is_ready, is_output_valid, dout, is_hit,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

endinterface
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
//  Module    : cache_line_store
//  Purpose   : Tag/valid/dirty/data arrays, one async read port, one write port
//  Revision  : 1.0  initial release
// ============================================================================
module cache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int INDEX_W  = index_width(NUM_SETS),
    parameter int TAG_W    = tag_width(NUM_SETS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               line_we,
    input  logic [TAG_W-1:0]   line_tag,
    input  logic [LINE_W-1:0]  line_data,
    input  logic               word_we,
    input  logic [1:0]         word_sel,
    input  logic [WORD_W-1:0]  word_data,
    input  logic               clean_we
);

    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    logic [TAG_W-1:0]    r_tag [NUM_SETS];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (line_we) begin
            r_valid[index] <= 1'b1;
            r_dirty[index] <= 1'b0;
        end else if (word_we) begin
            r_dirty[index] <= 1'b1;
        end else if (clean_we) begin
            r_dirty[index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            r_tag[index] <= line_tag;
        end
    end

    assign rd_tag   = r_tag[index];
    assign rd_valid = r_valid[index];
    assign rd_dirty = r_dirty[index];

    // One bank per word so a store touches a single word without read-modify-write
    generate
        for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : g_word
            logic [WORD_W-1:0] r_data [NUM_SETS];

            always_ff @(posedge clk) begin
                if (line_we) begin
                    r_data[index] <= line_data[w*WORD_W +: WORD_W];
                end else if (word_we && (word_sel == 2'(w))) begin
                    r_data[index] <= word_data;
                end
            end

            assign rd_line[w*WORD_W +: WORD_W] = r_data[index];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
//  Module    : data_cache
//  Purpose   : Direct-mapped write-back/write-allocate data cache for MEM stage.
//              Optional DATA_CACHE_STATS_EN adds hit_count/miss_count outputs.
//  Revision  : 1.0  initial release
// ============================================================================
module data_cache
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 16
) (
    input  logic        clk,
    input  logic        reset,
    data_cache_if.slave bus
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int INDEX_W  = index_width(NUM_SETS);
    localparam int TAG_W    = tag_width(NUM_SETS);
    localparam int OFFSET_W = offset_width();

    localparam logic [1:0] c_st_idle      = IDLE;
    localparam logic [1:0] c_st_compare   = COMPARE;
    localparam logic [1:0] c_st_writeback = WRITEBACK;
    localparam logic [1:0] c_st_allocate  = ALLOCATE;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_din;
    logic              r_is_store;
    logic              r_missed;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_dout;
    logic              r_hit;
    mem_req_t          r_req;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_word;
    logic [TAG_W-1:0]   w_stored_tag;
    logic               w_valid;
    logic               w_dirty;
    logic [LINE_W-1:0]  w_line;
    logic [WORD_W-1:0]  w_word_data;
    logic               w_hit;
    logic               w_accept;
    logic               w_resp;
    logic               w_unused;

    assign w_index     = r_addr[OFFSET_W +: INDEX_W];
    assign w_tag       = r_addr[ADDR_W-1 -: TAG_W];
    assign w_word      = r_addr[3:2];
    assign w_word_data = w_line[{w_word, 5'b0} +: WORD_W];
    assign w_hit       = w_valid && (w_stored_tag == w_tag);
    assign w_accept    = bus.is_input_valid && (r_state == c_st_idle) &&
                         (bus.mem_read || bus.mem_write);
    // A response only counts while our own request is outstanding
    assign w_resp      = bus.mem_resp_valid && r_req.valid;
    assign w_unused    = ^r_addr[1:0];

    cache_line_store #(
        .NUM_SETS (NUM_SETS)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .index     (w_index),
        .rd_tag    (w_stored_tag),
        .rd_valid  (w_valid),
        .rd_dirty  (w_dirty),
        .rd_line   (w_line),
        .line_we   ((r_state == c_st_allocate) && w_resp),
        .line_tag  (w_tag),
        .line_data (bus.mem_resp_data),
        .word_we   ((r_state == c_st_compare) && w_hit && r_is_store),
        .word_sel  (w_word),
        .word_data (r_din),
        .clean_we  ((r_state == c_st_writeback) && w_resp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_addr      <= '0;
            r_din       <= '0;
            r_is_store  <= 1'b0;
            r_missed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_hit       <= 1'b0;
            r_req       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state    <= c_st_compare;
                        r_addr     <= bus.addr;
                        r_din      <= bus.din;
                        r_is_store <= bus.mem_write;
                        r_missed   <= 1'b0;
                    end
                end
                c_st_compare: begin
                    if (w_hit) begin
                        r_state     <= c_st_idle;
                        r_out_valid <= 1'b1;
                        r_hit       <= !r_missed;
                        if (!r_is_store) begin
                            r_dout <= w_word_data;
                        end
                    end else begin
                        r_missed    <= 1'b1;
                        r_req.valid <= 1'b1;
                        if (w_valid && w_dirty) begin
                            r_state     <= c_st_writeback;
                            r_req.we    <= 1'b1;
                            r_req.addr  <= {w_stored_tag, w_index, {OFFSET_W{1'b0}}};
                            r_req.wdata <= w_line;
                        end else begin
                            r_state     <= c_st_allocate;
                            r_req.we    <= 1'b0;
                            r_req.addr  <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                            r_req.wdata <= '0;
                        end
                    end
                end
                c_st_writeback: begin
                    if (w_resp) begin
                        r_state     <= c_st_allocate;
                        r_req.valid <= 1'b0;
                    end
                end
                c_st_allocate: begin
                    // After a writeback the fill request goes out one idle cycle later
                    if (w_resp) begin
                        r_state     <= c_st_compare;
                        r_req.valid <= 1'b0;
                    end else if (!r_req.valid) begin
                        r_req.valid <= 1'b1;
                        r_req.we    <= 1'b0;
                        r_req.addr  <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                        r_req.wdata <= '0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.is_ready        = (r_state == c_st_idle);
    assign bus.is_output_valid = r_out_valid;
    assign bus.dout            = r_dout;
    assign bus.is_hit          = r_hit;
    assign bus.mem_req_valid   = r_req.valid;
    assign bus.mem_req_we      = r_req.we;
    assign bus.mem_req_addr    = r_req.addr;
    assign bus.mem_req_wdata   = r_req.wdata;

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if ((r_state == c_st_compare) && w_hit) begin
            if (r_missed) begin
                r_miss_count <= r_miss_count + 32'd1;
            end else begin
                r_hit_count <= r_hit_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire
